// File: rtl/reaction_timer_multi_if.sv
// Control and result bundle between the reaction timer core, the button
// debouncers and the bin2bcd / display path.
interface reaction_timer_multi_if #(
    parameter int N_PLAYERS = 2
);
    localparam int WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

    logic                    start_i;
    logic                    clear_i;
    logic [N_PLAYERS-1:0]    stop_i;
    logic                    stim_led_o;
    logic                    busy_o;
    logic                    done_o;
    logic [N_PLAYERS-1:0]    hit_o;
    logic [N_PLAYERS-1:0]    early_o;
    logic [14*N_PLAYERS-1:0] time_ms_o;
    logic [WIN_W-1:0]        winner_o;
    logic                    winner_vld_o;
    logic [14*N_PLAYERS-1:0] best_ms_o;

    modport master (
        output start_i, clear_i, stop_i,
        input  stim_led_o, busy_o, done_o, hit_o, early_o, time_ms_o,
               winner_o, winner_vld_o, best_ms_o
    );

    modport slave (
        input  start_i, clear_i, stop_i,
        output stim_led_o, busy_o, done_o, hit_o, early_o, time_ms_o,
               winner_o, winner_vld_o, best_ms_o
    );
endinterface

// File: rtl/reaction_timer_multi.sv
// N-player reaction timer: LFSR stimulus delay, per-player ms timing, false-start
// detection and winner arbitration. REACTION_TIMER_BEST_TIME_EN adds best-time registers.

module reaction_timer_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        dly,
    input  logic        stm,
    input  logic        tmo,
    input  logic [13:0] cnt,
    input  logic        stop,
    output logic        hit,
    output logic        early,
    output logic        hit_now,
    output logic [13:0] time_ms,
    output logic [13:0] best_ms
);
    logic live;

    assign live    = !hit && !early;
    assign hit_now = stm && stop && live;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            hit     <= 1'b0;
            early   <= 1'b0;
            time_ms <= '0;
        end else if (dly && stop && live) begin
            early   <= 1'b1;
            time_ms <= 14'd9999;
        end else if (hit_now) begin
            hit     <= 1'b1;
            time_ms <= cnt;
        end else if (tmo && live) begin
            time_ms <= 14'd9999;
        end
    end

`ifdef REACTION_TIMER_BEST_TIME_EN
    // Only rst_n forgets the best time; a clear between rounds keeps it.
    always_ff @(posedge clk) begin
        if (!rst_n)
            best_ms <= 14'd9999;
        else if (hit_now && cnt < best_ms)
            best_ms <= cnt;
    end
`else
    assign best_ms = 14'd9999;
`endif
endmodule

module reaction_timer_multi #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int N_PLAYERS   = 2,
    parameter int MIN_DELAY_S = 2,
    parameter int MAX_DELAY_S = 15,
    parameter int TIMEOUT_MS  = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reaction_timer_multi_if.slave bus
);
    localparam int          TICK_DIV = CLK_HZ / 1000;
    localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          WW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int          RANGE    = MAX_DELAY_S - MIN_DELAY_S + 1;
    localparam logic [13:0] MS_SAT   = 14'd9999;

    typedef enum logic [1:0] {IDLE, DELAY, STIM, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]                 lfsr;
    logic [PW-1:0]              presc;
    logic [13:0]                cnt, delay_ms;
    logic [N_PLAYERS-1:0]       hit, early, hit_now;
    logic [N_PLAYERS-1:0][13:0] time_ms, best_ms;
    logic [WW-1:0]              winner, first_hit;
    logic                       winner_vld, tick, go, clr_res, timeout;
    logic                       in_dly, in_stm, in_tmo;

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign go      = bus.start_i && (state == IDLE || state == DONE);
    assign clr_res = bus.clear_i || go;
    assign timeout = (state == STIM) && (cnt == 14'(TIMEOUT_MS));
    assign in_dly  = (state == DELAY) && !bus.clear_i;
    assign in_stm  = (state == STIM) && !bus.clear_i && !timeout;
    assign in_tmo  = timeout && !bus.clear_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i) state_nxt = DELAY;
            DELAY:   if (&(early | bus.stop_i)) state_nxt = DONE;
                     else if (tick && cnt == delay_ms - 14'd1) state_nxt = STIM;
            STIM:    if (&(hit | early) || timeout) state_nxt = DONE;
            DONE:    if (bus.start_i) state_nxt = DELAY;
            default: state_nxt = IDLE;
        endcase
        if (bus.clear_i) state_nxt = IDLE;
    end

    // Lowest index wins among same-cycle hits.
    always_comb begin
        first_hit = '0;
        for (int k = N_PLAYERS - 1; k >= 0; k--)
            if (hit_now[k]) first_hit = WW'(k);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= 8'hA5;
            presc      <= '0;
            cnt        <= '0;
            delay_ms   <= '0;
            winner     <= '0;
            winner_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state_nxt != state || tick) presc <= '0;
            else                            presc <= presc + 1'b1;
            // DELAY stops at its target on its own; only the reaction count needs a ceiling.
            if (state_nxt != state)
                cnt <= '0;
            else if (tick && (state == DELAY || (state == STIM && cnt != MS_SAT)))
                cnt <= cnt + 14'd1;
            if (go)
                delay_ms <= 14'((MIN_DELAY_S + int'(lfsr) % RANGE) * 1000);
            if (clr_res) begin
                winner     <= '0;
                winner_vld <= 1'b0;
            end else if (|hit_now && !winner_vld) begin
                winner     <= first_hit;
                winner_vld <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_PLAYERS; k++) begin : g_lane
        reaction_timer_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr_res),
            .dly     (in_dly),
            .stm     (in_stm),
            .tmo     (in_tmo),
            .cnt     (cnt),
            .stop    (bus.stop_i[k]),
            .hit     (hit[k]),
            .early   (early[k]),
            .hit_now (hit_now[k]),
            .time_ms (time_ms[k]),
            .best_ms (best_ms[k])
        );
    end

    assign bus.stim_led_o   = (state == STIM);
    assign bus.busy_o       = (state == DELAY) || (state == STIM);
    assign bus.done_o       = (state == DONE);
    assign bus.hit_o        = hit;
    assign bus.early_o      = early;
    assign bus.time_ms_o    = time_ms;
    assign bus.best_ms_o    = best_ms;
    assign bus.winner_o     = winner;
    assign bus.winner_vld_o = winner_vld;
endmodule

// File: tb/tb_reaction_timer_multi.sv
// Scoreboard bench for reaction_timer_multi: 2 players, 2 clk per ms, 1..2 s delay.
module tb_reaction_timer_multi;
    localparam int NP     = 2;
    localparam int CLK_HZ = 2000;
    localparam int TK     = CLK_HZ / 1000;
    localparam int MIN_S  = 1;
    localparam int MAX_S  = 2;
    localparam int TMO    = 9999;
    localparam int WW     = 1;

    typedef struct {
        logic [NP-1:0]    hit;
        logic [NP-1:0]    early;
        logic [14*NP-1:0] tm;
        logic [14*NP-1:0] best;
        logic [WW-1:0]    win;
        logic             vld;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reaction_timer_multi_if #(.N_PLAYERS(NP)) bus ();

    reaction_timer_multi #(
        .CLK_HZ(CLK_HZ), .N_PLAYERS(NP), .MIN_DELAY_S(MIN_S),
        .MAX_DELAY_S(MAX_S), .TIMEOUT_MS(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic [7:0] m_lfsr;
    int         m_best    [NP];
    int         plan_kind [NP];   // 0 = early press, 1 = press after stimulus, 2 = no press
    int         plan_ms   [NP];
    int         plan_sub  [NP];
    exp_t       exp_q [$];
    int         stim_q [$];
    exp_t       mon_e;
    logic       stim_prev = 1'b0;
    logic       done_prev = 1'b0;

    // Feedback is the parity of taps 8,6,5,4.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected by the scoreboard", nm);
    endtask

    function automatic logic [14*NP-1:0] pack_best();
        logic [14*NP-1:0] v;
        for (int k = 0; k < NP; k++) v[14*k +: 14] = 14'(m_best[k]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.stim_led_o && !stim_prev) begin
                if (stim_q.size() == 0) flag("stim_rise");
                else chk("stim_cycle", 64'(cyc), 64'(stim_q.pop_front()));
            end
            if (bus.done_o && !done_prev) begin
                if (exp_q.size() == 0) flag("done_rise");
                else begin
                    mon_e = exp_q.pop_front();
                    chk("done_led",    bus.stim_led_o,   0);
                    chk("done_hit",    bus.hit_o,        mon_e.hit);
                    chk("done_early",  bus.early_o,      mon_e.early);
                    chk("done_time",   bus.time_ms_o,    mon_e.tm);
                    chk("done_vld",    bus.winner_vld_o, mon_e.vld);
                    chk("done_winner", bus.winner_o,     mon_e.win);
                    chk("done_best",   bus.best_ms_o,    mon_e.best);
                end
            end
        end
        stim_prev = bus.stim_led_o;
        done_prev = bus.done_o;
    end

    task automatic set_plan(input int k0, input int m0, input int s0,
                            input int k1, input int m1, input int s1);
        plan_kind[0] = k0; plan_ms[0] = m0; plan_sub[0] = s0;
        plan_kind[1] = k1; plan_ms[1] = m1; plan_sub[1] = s1;
    endtask

    // Called at a negedge; plays one round of plan_* and predicts its outcome.
    task automatic run_round(input bit poke, input int clr_ms);
        exp_t          e;
        int            d_s, c0, s_cyc, best_t;
        bit            all_early, done_seen;
        logic [NP-1:0] stp;
        d_s       = MIN_S + int'(m_lfsr) % (MAX_S - MIN_S + 1);
        c0        = cyc;
        s_cyc     = c0 + 1 + d_s * 1000 * TK;
        all_early = 1'b1;
        best_t    = 10000;
        e.hit = '0; e.early = '0; e.tm = '0; e.best = '0; e.win = '0; e.vld = 1'b0;
        for (int k = 0; k < NP; k++) begin
            case (plan_kind[k])
                0: begin
                    e.early[k] = 1'b1;
                    e.tm[14*k +: 14] = 14'd9999;
                end
                1: begin
                    e.hit[k] = 1'b1;
                    e.tm[14*k +: 14] = 14'(plan_ms[k]);
                    all_early = 1'b0;
                    if (plan_ms[k] < best_t) begin
                        best_t = plan_ms[k];
                        e.win  = WW'(k);
                        e.vld  = 1'b1;
                    end
`ifdef REACTION_TIMER_BEST_TIME_EN
                    if (plan_ms[k] < m_best[k]) m_best[k] = plan_ms[k];
`endif
                end
                default: begin
                    e.tm[14*k +: 14] = 14'd9999;
                    all_early = 1'b0;
                end
            endcase
        end
        e.best = pack_best();
        if (clr_ms < 0) exp_q.push_back(e);
        if (!all_early) stim_q.push_back(s_cyc);
        bus.start_i = 1'b1;
        done_seen   = 1'b0;
        for (int t = 0; t < 40000 && !done_seen; t++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            bus.clear_i = 1'b0;
            if (bus.done_o) begin
                done_seen = 1'b1;
            end else begin
                stp = '0;
                for (int k = 0; k < NP; k++) begin
                    if (plan_kind[k] == 0 && cyc == c0 + 1 + plan_ms[k] * TK + plan_sub[k])
                        stp[k] = 1'b1;
                    if (plan_kind[k] == 1 && (cyc == s_cyc + plan_ms[k] * TK + plan_sub[k] ||
                                              cyc == s_cyc + (plan_ms[k] + 3) * TK))
                        stp[k] = 1'b1;
                end
                bus.stop_i = stp;
                if (poke && (cyc == c0 + 50 || cyc == s_cyc + 20)) bus.start_i = 1'b1;
                if (clr_ms >= 0 && cyc == s_cyc + clr_ms * TK) begin
                    bus.clear_i = 1'b1;
                    bus.start_i = 1'b1;
                    bus.stop_i  = '1;
                    @(negedge clk);
                    bus.clear_i = 1'b0;
                    bus.start_i = 1'b0;
                    bus.stop_i  = '0;
                    chk("clr_led",   bus.stim_led_o,   0);
                    chk("clr_busy",  bus.busy_o,       0);
                    chk("clr_done",  bus.done_o,       0);
                    chk("clr_hit",   bus.hit_o,        0);
                    chk("clr_early", bus.early_o,      0);
                    chk("clr_time",  bus.time_ms_o,    0);
                    chk("clr_vld",   bus.winner_vld_o, 0);
                    chk("clr_best",  bus.best_ms_o,    pack_best());
                    repeat (20) @(negedge clk);
                    chk("clr_stays_idle", bus.busy_o,  0);
                    done_seen = 1'b1;
                end
            end
        end
        bus.stop_i  = '0;
        bus.start_i = 1'b0;
        if (!done_seen) begin
            vectors++;
            miscompares++;
            $display("FAIL round_end: done_o not seen within 40000 cycles, want done_o=1");
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.clear_i = 1'b0;
        bus.stop_i  = '0;
        for (int k = 0; k < NP; k++) m_best[k] = 9999;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("rst_led",    bus.stim_led_o,   0);
        chk("rst_busy",   bus.busy_o,       0);
        chk("rst_done",   bus.done_o,       0);
        chk("rst_hit",    bus.hit_o,        0);
        chk("rst_early",  bus.early_o,      0);
        chk("rst_time",   bus.time_ms_o,    0);
        chk("rst_winner", bus.winner_o,     0);
        chk("rst_vld",    bus.winner_vld_o, 0);
        chk("rst_best",   bus.best_ms_o,    {14'd9999, 14'd9999});

        set_plan(1, 123, 0, 1, 200, 1);  run_round(1'b1, -1);  // basic round, stray starts
        set_plan(1, 50, 1, 0, 500, 0);   run_round(1'b0, -1);  // p1 false start
        set_plan(1, 77, 0, 1, 77, 0);    run_round(1'b0, -1);  // same-cycle tie
        set_plan(0, 200, 0, 0, 700, 1);  run_round(1'b0, -1);  // everyone early
        set_plan(1, 60, 0, 1, 30, 1);    run_round(1'b0, -1);  // p1 faster
        set_plan(2, 0, 0, 2, 0, 0);      run_round(1'b0, -1);  // nobody reacts
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NP; k++) begin
                plan_kind[k] = ($urandom_range(0, 3) == 0) ? 0 : 1;
                plan_ms[k]   = (plan_kind[k] == 0) ? int'($urandom_range(0, 900))
                                                   : int'($urandom_range(0, 300));
                plan_sub[k]  = int'($urandom_range(0, TK - 1));
            end
            run_round(1'b0, -1);
        end
        set_plan(1, 40, 0, 2, 0, 0);     run_round(1'b0, 100); // clear+start mid STIM

        chk("queues_drained", 64'(exp_q.size() + stim_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
